// File: rtl/seq_det_pkg.sv
// Shared types and sizing for the sequence-detect session controller.
// The state encoding and the window-count helper are used by the top module and by the window comparator.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_PAT_W  = 2;

    // Number of PAT_W-wide sliding windows inside a DATA_W-wide word.
    function automatic int calc_nwin(input int data_w, input int pat_w);
        return data_w - pat_w + 1;
    endfunction

endpackage

// File: rtl/seq_win_cmp.sv
// Combinational window select plus equality compare.
// Window i is taken MSB-first from the snapshot.
module seq_win_cmp
    import seq_det_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PAT_W  = DEF_PAT_W,
    parameter int IDX_W  = 2
) (
    input  logic [DATA_W-1:0] i_shadow,
    input  logic [PAT_W-1:0]  i_pat,
    input  logic [IDX_W-1:0]  i_idx,
    output logic              o_match
);

    localparam int NWIN = calc_nwin(DATA_W, PAT_W);

    logic [NWIN-1:0] w_eq;

    genvar gi;
    generate
        for (gi = 0; gi < NWIN; gi++) begin : g_win
            assign w_eq[gi] = (i_shadow[DATA_W-1-gi -: PAT_W] == i_pat);
        end
    endgenerate

    // Index values outside the window range yield no match.
    always_comb begin
        o_match = 1'b0;
        for (int i = 0; i < NWIN; i++) begin
            if (i_idx == IDX_W'(i)) begin
                o_match = w_eq[i];
            end
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Session controller: selects the pattern, snapshots the switch word while running,
// then scans the windows one per clock through a single comparator and publishes the count.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int PAT_W  = DEF_PAT_W,
    localparam int NWIN   = calc_nwin(DATA_W, PAT_W),
    localparam int IDX_W  = (NWIN > 1) ? $clog2(NWIN) : 1,
    localparam int CNT_W  = $clog2(NWIN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_pat_pulse,
    input  logic              key_det_pulse,
    input  logic [DATA_W-1:0] bm,
    output logic [PAT_W-1:0]  pat,
    output logic              det_active,
    output logic              busy,
    output logic [IDX_W-1:0]  scan_idx,
    output logic [CNT_W-1:0]  result,
    output logic              result_valid
);

    state_t            r_state;
    state_t            w_state_next;
    logic [PAT_W-1:0]  r_pat;
    logic [DATA_W-1:0] r_shadow;
    logic [CNT_W-1:0]  r_acc;
    logic [IDX_W-1:0]  r_scan_idx;
    logic [CNT_W-1:0]  r_result;
    logic              r_result_valid;
    logic              w_match;

    seq_win_cmp #(
        .DATA_W (DATA_W),
        .PAT_W  (PAT_W),
        .IDX_W  (IDX_W)
    ) u_win_cmp (
        .i_shadow (r_shadow),
        .i_pat    (r_pat),
        .i_idx    (r_scan_idx),
        .o_match  (w_match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (key_det_pulse) w_state_next = ST_RUN;
            ST_RUN:  if (key_det_pulse) w_state_next = ST_SCAN;
            ST_SCAN: if (r_scan_idx == IDX_W'(NWIN - 1)) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath registers; keys are only honoured in IDLE and RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat          <= '0;
            r_shadow       <= '0;
            r_acc          <= '0;
            r_scan_idx     <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (key_pat_pulse && !key_det_pulse) begin
                        r_pat <= r_pat + PAT_W'(1);
                    end
                end
                ST_RUN: begin
                    r_shadow <= bm;
                    if (key_det_pulse) begin
                        r_acc      <= '0;
                        r_scan_idx <= '0;
                    end
                end
                ST_SCAN: begin
                    r_acc      <= r_acc + CNT_W'(w_match);
                    r_scan_idx <= r_scan_idx + IDX_W'(1);
                end
                ST_DONE: begin
                    r_result       <= r_acc;
                    r_result_valid <= 1'b1;
                    r_scan_idx     <= '0;
                end
                default: ;
            endcase
        end
    end

    assign pat          = r_pat;
    assign det_active   = (r_state == ST_RUN);
    assign busy         = (r_state == ST_SCAN) || (r_state == ST_DONE);
    assign scan_idx     = r_scan_idx;
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule
